// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
// Shared constants for the instruction-fetch front end.
//   INSN_WIDTH : width of one instruction word
//   PC_STEP    : byte increment between sequential fetch addresses
// Queue entries are laid out as {pc, insn}, with the instruction in the
// low INSN_WIDTH bits.
package fetch_buffer_pkg;

  localparam int INSN_WIDTH = 32;
  localparam int PC_STEP    = 4;

endpackage

// File: rtl/fetch_buffer_fifo.sv
// fetch_fifo
// Circular buffer holding fetched {pc, insn} entries for decode.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push       write wr_data at the tail (ignored when full, unless popping)
//   pop        drop the head entry (ignored when empty)
//   clear      empty the buffer (takes priority over push/pop)
//   wr_data    entry to write
//   rd_data    head entry (valid when !empty; all zeros after reset)
//   full       DEPTH entries stored
//   empty      no entries stored
//   count      number of stored entries
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // One extra pointer bit distinguishes full from empty after wrap-around.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = CW'(wr_ptr_q - rd_ptr_q);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (do_push && !clear && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Instruction-fetch front end: keeps up to DEPTH requests in flight to
// instruction memory and queues returned instructions with their PCs for
// decode. A redirect flushes the queue and discards stale responses.
// Optional feature macro: FETCH_BUF_BYPASS_EN -- a response arriving into an
// empty queue is presented to decode in the same cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect, redirect_pc    flush and restart fetch at redirect_pc (word aligned)
//   imem_req_*               request channel (valid/ready, address)
//   imem_rsp_valid/data      in-order responses, no backpressure
//   ir_valid/ir_ready        decode handshake
//   ir, ir_pc                instruction and its PC
//   occupancy                entries held in the queue
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [XLEN-1:0]              imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSN_WIDTH-1:0]        imem_rsp_data,
  output logic                         ir_valid,
  input  logic                         ir_ready,
  output logic [INSN_WIDTH-1:0]        ir,
  output logic [XLEN-1:0]              ir_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + INSN_WIDTH;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [XLEN-1:0] redirect_base;
  logic [CW:0]     in_use;
  logic            req_fire, rsp_accept, rsp_keep;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_head;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit: queued entries plus in-flight requests never exceed DEPTH, so
  // every returning response is guaranteed a slot.
  assign in_use         = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign imem_req_valid = !rst && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and ignored.
  assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
  // The response landing in a redirect cycle belongs to the old stream.
  assign rsp_keep   = rsp_accept && (discard_q == '0) && !redirect;

`ifdef FETCH_BUF_BYPASS_EN
  logic byp;
  assign byp       = rsp_keep && fifo_empty;
  assign ir_valid  = !fifo_empty || byp;
  assign ir        = byp ? imem_rsp_data : fifo_head[INSN_WIDTH-1:0];
  assign ir_pc     = byp ? rsp_pc_q : fifo_head[EW-1:INSN_WIDTH];
  // A bypassed instruction taken by decode never enters the queue.
  assign fifo_push = rsp_keep && !(byp && ir_ready);
`else
  assign ir_valid  = !fifo_empty;
  assign ir        = fifo_head[INSN_WIDTH-1:0];
  assign ir_pc     = fifo_head[EW-1:INSN_WIDTH];
  assign fifo_push = rsp_keep;
`endif

  assign fifo_pop = !fifo_empty && ir_ready && !redirect;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (redirect),
    .wr_data ({rsp_pc_q, imem_rsp_data}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (req_fire && !rsp_accept)      outstanding_d = outstanding_q + CW'(1);
    else if (!req_fire && rsp_accept) outstanding_d = outstanding_q - CW'(1);

    if (redirect) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      // Everything still in flight after this cycle is stale.
      discard_d  = outstanding_q - CW'(rsp_accept);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + XLEN'(PC_STEP);
      if (rsp_accept && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

`ifndef SYNTHESIS
  rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding_q == '0)));
`endif

endmodule
